// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered release of downstream domain resets with
// ready supervision, plus a stretched software reset request pulse.
//
// Ports:
//   CLK            system clock
//   FABRIC_RESET_N async active-low reset from the fabric generator
//   SW_RST_REQ     software reset request (level or pulse)
//   STAGE_READY    per-stage ready, synchronous to CLK
//   STAGE_RESET_N  per-stage active-low reset, registered
//   ALL_READY      every stage released and ready
//   SEQ_ERROR      sticky fault flag
//   ERR_STAGE      index of the faulting stage
//   EXT_RST_REQ_N  active-low request to the generator's EXT_RST_N
module reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int PULSE_CYCLES   = 8
) (
  input  logic                  CLK,
  input  logic                  FABRIC_RESET_N,
  input  logic                  SW_RST_REQ,
  input  logic [NUM_STAGES-1:0] STAGE_READY,
  output logic [NUM_STAGES-1:0] STAGE_RESET_N,
  output logic                  ALL_READY,
  output logic                  SEQ_ERROR,
  output logic [3:0]            ERR_STAGE,
  output logic                  EXT_RST_REQ_N
);

  localparam int M0 =
    (SETTLE_CYCLES > GAP_CYCLES) ?
    SETTLE_CYCLES : GAP_CYCLES;
  localparam int M1 =
    (TIMEOUT_CYCLES > PULSE_CYCLES) ?
    TIMEOUT_CYCLES : PULSE_CYCLES;
  localparam int CMAX = (M0 > M1) ? M0 : M1;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SETTLE_LAST =
    CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST =
    CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST =
    CW'(PULSE_CYCLES - 1);
  localparam logic [3:0] LAST_IDX =
    4'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    HOLD,
    WAIT_RDY,
    GAP,
    RUN,
    FAULT,
    REQ
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [3:0]      idx;

  // One-hot of the stage being waited on; avoids a
  // variable bit-select into STAGE_READY.
  logic [NUM_STAGES-1:0] sel;
  logic                  rdy_cur;
  logic                  last;

  assign sel     = NUM_STAGES'(1) << idx;
  assign rdy_cur = |(STAGE_READY & sel);
  assign last    = (idx == LAST_IDX);

  function automatic logic [3:0] first_low(
    input logic [NUM_STAGES-1:0] r
  );
    logic [3:0] f;
    f = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (!r[k]) f = 4'(k);
    end
    return f;
  endfunction

  always_ff @(posedge CLK or negedge FABRIC_RESET_N) begin
    if (!FABRIC_RESET_N) begin
      state         <= HOLD;
      cnt           <= '0;
      idx           <= '0;
      STAGE_RESET_N <= '0;
      ALL_READY     <= 1'b0;
      SEQ_ERROR     <= 1'b0;
      ERR_STAGE     <= '0;
      EXT_RST_REQ_N <= 1'b1;
    end else if (SW_RST_REQ && state != REQ) begin
      // Software request wins over every other event.
      state         <= REQ;
      cnt           <= '0;
      idx           <= '0;
      STAGE_RESET_N <= '0;
      ALL_READY     <= 1'b0;
      SEQ_ERROR     <= 1'b0;
      ERR_STAGE     <= '0;
      EXT_RST_REQ_N <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == SETTLE_LAST) begin
            cnt           <= '0;
            idx           <= '0;
            STAGE_RESET_N <= NUM_STAGES'(1);
            state         <= WAIT_RDY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_RDY: begin
          if (rdy_cur) begin
            cnt <= '0;
            if (last) begin
              state     <= RUN;
              ALL_READY <= 1'b1;
            end else begin
              state <= GAP;
            end
          end else if (cnt == TO_LAST) begin
            cnt           <= '0;
            state         <= FAULT;
            SEQ_ERROR     <= 1'b1;
            ERR_STAGE     <= idx;
            STAGE_RESET_N <= '0;
            ALL_READY     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt           <= '0;
            STAGE_RESET_N <= STAGE_RESET_N | (sel << 1);
            idx           <= idx + 1'b1;
            state         <= WAIT_RDY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (~STAGE_READY != '0) begin
            state         <= FAULT;
            SEQ_ERROR     <= 1'b1;
            ERR_STAGE     <= first_low(STAGE_READY);
            STAGE_RESET_N <= '0;
            ALL_READY     <= 1'b0;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        REQ: begin
          if (cnt == PULSE_LAST) begin
            cnt           <= '0;
            EXT_RST_REQ_N <= 1'b1;
            state         <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= HOLD;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed bench for reset_sequencer
// with default parameters.
module tb_reset_sequencer;

  logic       CLK;
  logic       FABRIC_RESET_N;
  logic       SW_RST_REQ;
  logic [3:0] STAGE_READY;
  logic [3:0] STAGE_RESET_N;
  logic       ALL_READY;
  logic       SEQ_ERROR;
  logic [3:0] ERR_STAGE;
  logic       EXT_RST_REQ_N;

  int tests;
  int fails;

  reset_sequencer dut (
    .CLK           (CLK),
    .FABRIC_RESET_N(FABRIC_RESET_N),
    .SW_RST_REQ    (SW_RST_REQ),
    .STAGE_READY   (STAGE_READY),
    .STAGE_RESET_N (STAGE_RESET_N),
    .ALL_READY     (ALL_READY),
    .SEQ_ERROR     (SEQ_ERROR),
    .ERR_STAGE     (ERR_STAGE),
    .EXT_RST_REQ_N (EXT_RST_REQ_N)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_rn"}, 32'(STAGE_RESET_N), 32'h0);
    check({tag, "_ar"}, 32'(ALL_READY), 32'h0);
    check({tag, "_se"}, 32'(SEQ_ERROR), 32'h0);
    check({tag, "_es"}, 32'(ERR_STAGE), 32'h0);
    check({tag, "_ext"}, 32'(EXT_RST_REQ_N), 32'h1);
  endtask

  // Called right after reset release or HOLD entry,
  // with all ready low; ends in RUN.
  task automatic nominal();
    logic [31:0] m;
    step(15);
    check("hold15", 32'(STAGE_RESET_N), 32'h0);
    step(1);
    check("rel0", 32'(STAGE_RESET_N), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step(3);
      STAGE_READY[i] = 1'b1;
      step(1);
      if (i < 3) begin
        m = (32'h1 << (i + 1)) - 1;
        check("gap_ar", 32'(ALL_READY), 32'h0);
        step(3);
        check("gap_hold", 32'(STAGE_RESET_N), m);
        step(1);
        m = (32'h1 << (i + 2)) - 1;
        check("rel_next", 32'(STAGE_RESET_N), m);
      end else begin
        check("run_ar", 32'(ALL_READY), 32'h1);
        check("run_rn", 32'(STAGE_RESET_N), 32'hf);
        check("run_se", 32'(SEQ_ERROR), 32'h0);
      end
    end
  endtask

  // From reset release: stages 0,1 become ready,
  // stage 2 is released and never answers.
  task automatic upto_stage2();
    step(16);
    step(3);
    STAGE_READY[0] = 1'b1;
    step(5);
    step(3);
    STAGE_READY[1] = 1'b1;
    step(5);
    check("s2_rel", 32'(STAGE_RESET_N), 32'h7);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2;
    FABRIC_RESET_N = 1'b0;
    STAGE_READY    = 4'b0000;
    SW_RST_REQ     = 1'b0;
    @(negedge CLK);
    FABRIC_RESET_N = 1'b1;
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    SW_RST_REQ     = 1'b0;
    STAGE_READY    = 4'b0000;
    FABRIC_RESET_N = 1'b1;
    #1;
    FABRIC_RESET_N = 1'b0;
    #1;
    chk_reset_vals("rst");
    step(3);
    chk_reset_vals("rst_hold");
    FABRIC_RESET_N = 1'b1;

    // Nominal release, then ready loss on 1 and 3.
    nominal();
    STAGE_READY = 4'b0101;
    step(1);
    check("loss_es", 32'(ERR_STAGE), 32'h1);
    check("loss_se", 32'(SEQ_ERROR), 32'h1);
    check("loss_rn", 32'(STAGE_RESET_N), 32'h0);
    check("loss_ar", 32'(ALL_READY), 32'h0);

    // Timeout on stage 2, stays in FAULT.
    do_reset();
    upto_stage2();
    step(1023);
    check("to_pre_se", 32'(SEQ_ERROR), 32'h0);
    check("to_pre_rn", 32'(STAGE_RESET_N), 32'h7);
    step(1);
    check("to_se", 32'(SEQ_ERROR), 32'h1);
    check("to_es", 32'(ERR_STAGE), 32'h2);
    check("to_rn", 32'(STAGE_RESET_N), 32'h0);
    check("to_ar", 32'(ALL_READY), 32'h0);
    step(20);
    check("fault_stay", 32'(SEQ_ERROR), 32'h1);
    check("fault_rn", 32'(STAGE_RESET_N), 32'h0);

    // Software reset out of FAULT clears the flags.
    STAGE_READY = 4'b0000;
    SW_RST_REQ  = 1'b1;
    step(1);
    SW_RST_REQ  = 1'b0;
    check("fr_se", 32'(SEQ_ERROR), 32'h0);
    check("fr_es", 32'(ERR_STAGE), 32'h0);
    check("fr_ext", 32'(EXT_RST_REQ_N), 32'h0);
    step(7);
    check("fr_ext7", 32'(EXT_RST_REQ_N), 32'h0);
    step(1);
    check("fr_ext8", 32'(EXT_RST_REQ_N), 32'h1);
    nominal();

    // Software pulse in RUN, ready drops with it.
    SW_RST_REQ  = 1'b1;
    STAGE_READY = 4'b0000;
    step(1);
    SW_RST_REQ  = 1'b0;
    check("sw_ext", 32'(EXT_RST_REQ_N), 32'h0);
    check("sw_rn", 32'(STAGE_RESET_N), 32'h0);
    check("sw_ar", 32'(ALL_READY), 32'h0);
    check("sw_se", 32'(SEQ_ERROR), 32'h0);
    step(7);
    check("sw_ext7", 32'(EXT_RST_REQ_N), 32'h0);
    step(1);
    check("sw_ext8", 32'(EXT_RST_REQ_N), 32'h1);
    nominal();

    // Request on the timeout cycle, held through REQ.
    do_reset();
    upto_stage2();
    step(1023);
    SW_RST_REQ = 1'b1;
    step(1);
    check("pri_ext", 32'(EXT_RST_REQ_N), 32'h0);
    check("pri_se", 32'(SEQ_ERROR), 32'h0);
    check("pri_es", 32'(ERR_STAGE), 32'h0);
    step(7);
    check("held_ext7", 32'(EXT_RST_REQ_N), 32'h0);
    step(1);
    check("held_exit", 32'(EXT_RST_REQ_N), 32'h1);
    step(1);
    check("held_reent", 32'(EXT_RST_REQ_N), 32'h0);
    SW_RST_REQ  = 1'b0;
    STAGE_READY = 4'b0000;
    step(7);
    check("reent_ext7", 32'(EXT_RST_REQ_N), 32'h0);
    step(1);
    check("reent_ext8", 32'(EXT_RST_REQ_N), 32'h1);
    nominal();

    // Async reset while in GAP.
    do_reset();
    step(16);
    step(3);
    STAGE_READY[0] = 1'b1;
    step(2);
    check("gap_pre", 32'(STAGE_RESET_N), 32'h1);
    #2;
    FABRIC_RESET_N = 1'b0;
    #1;
    chk_reset_vals("ar_gap");
    STAGE_READY = 4'b0000;
    @(negedge CLK);
    FABRIC_RESET_N = 1'b1;
    nominal();

    // Async reset during the request pulse.
    SW_RST_REQ = 1'b1;
    step(1);
    SW_RST_REQ = 1'b0;
    STAGE_READY = 4'b0000;
    step(3);
    check("ar_pls_pre", 32'(EXT_RST_REQ_N), 32'h0);
    #2;
    FABRIC_RESET_N = 1'b0;
    #1;
    chk_reset_vals("ar_pls");
    @(negedge CLK);
    FABRIC_RESET_N = 1'b1;
    nominal();

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumer end of the fabric reset generator: takes FABRIC_RESET_N as its reset and releases NUM_STAGES downstream domain resets in a fixed order.
- Each stage is released only after the previous stage reports ready.
- Supervises the ready signals after release and flags timeouts and ready loss.
- In the other direction, turns a software reset request into a stretched active-low pulse that drives the generator's EXT_RST_N input.

Parameters:
NUM_STAGES, 4, number of sequenced reset domains (1..16)
SETTLE_CYCLES, 16, CLK cycles held after reset deassertion before stage 0 is released (>=1)
GAP_CYCLES, 4, CLK cycles between stage i ready and stage i+1 release (>=1)
TIMEOUT_CYCLES, 1024, maximum CLK cycles to wait for a released stage's ready (>=2)
PULSE_CYCLES, 8, width of the EXT_RST_REQ_N low pulse in CLK cycles (>=1)

Ports:
CLK  in  1  system clock
FABRIC_RESET_N  in  1  reset, asynchronous assert, active-low; deassertion already synchronous to CLK
SW_RST_REQ  in  1  software reset request, sampled each cycle, level or pulse
STAGE_READY  in  NUM_STAGES  per-stage ready, synchronous to CLK
STAGE_RESET_N  out  NUM_STAGES  per-stage reset, active-low, registered
ALL_READY  out  1  high while every stage is released and ready
SEQ_ERROR  out  1  sticky fault flag
ERR_STAGE  out  4  index of the faulting stage
EXT_RST_REQ_N  out  1  active-low reset request to the generator's EXT_RST_N

Behaviour:
- Reset (FABRIC_RESET_N=0), applied immediately:
  - STAGE_RESET_N = all 0; ALL_READY=0; SEQ_ERROR=0; ERR_STAGE=0; EXT_RST_REQ_N=1.
  - state=HOLD; counters=0; stage index=0.
- All outputs are registered; no combinational path from any input to any output.
- States: HOLD, WAIT_RDY, GAP, RUN, FAULT, REQ.
- HOLD:
  - Counts SETTLE_CYCLES edges.
  - On the SETTLE_CYCLES-th edge after reset deassertion: STAGE_RESET_N[0] goes to 1, then WAIT_RDY with index=0.
- WAIT_RDY(i):
  - Timeout counter starts at 0 on entry and increments each cycle.
  - STAGE_READY[i]=1 sampled:
    - If i<NUM_STAGES-1, go to GAP.
    - If i is the last stage, go to RUN; ALL_READY=1 on the same edge.
  - Counter reaches TIMEOUT_CYCLES-1 with ready still low: go to FAULT.
  - Ready beats timeout when both occur on the same cycle.
- GAP:
  - Counts GAP_CYCLES edges.
  - On the last edge: STAGE_RESET_N[i+1]=1, index=i+1, then WAIT_RDY.
- STAGE_READY bits of stages not yet released are ignored in every state.
- RUN:
  - ALL_READY=1.
  - Any STAGE_READY bit low: go to FAULT; ERR_STAGE = lowest low index; ALL_READY=0 on the same edge.
- FAULT (entry edge):
  - SEQ_ERROR=1; ERR_STAGE = faulting index (timeout uses the index being waited on).
  - STAGE_RESET_N = all 0; ALL_READY=0.
  - Stays in FAULT until SW_RST_REQ or reset.
- REQ:
  - Entered from any state except REQ when SW_RST_REQ=1.
  - SW_RST_REQ has priority over ready, timeout and gap completion on the same cycle.
  - Entry edge: EXT_RST_REQ_N=0; STAGE_RESET_N = all 0; ALL_READY=0; SEQ_ERROR=0; ERR_STAGE=0.
  - EXT_RST_REQ_N is held low for exactly PULSE_CYCLES cycles, then returns to 1 and the block enters HOLD with counters cleared.
  - SW_RST_REQ held high during REQ is ignored; if it is still high on the first HOLD cycle, REQ is re-entered.
- Normal loop-back: the generator asserts FABRIC_RESET_N during or after the pulse, which asynchronously forces the reset state. If it does not, HOLD restarts the sequence anyway.
- Reset mid-sequence, in any state including REQ: all outputs return to reset values immediately; any pulse in progress is aborted with EXT_RST_REQ_N=1.
- Once released, a stage stays released until FAULT, REQ or reset. Stages are never released out of order.
- Counters are sized to their parameter maxima and never wrap.

Test Plan:
- Nominal release: defaults, each STAGE_READY[i] rises 3 cycles after STAGE_RESET_N[i] -> STAGE_RESET_N[0] rises 16 edges after reset deassertion; each later bit rises 4 edges after the previous ready; ALL_READY rises on the edge stage 3 ready is sampled; SEQ_ERROR=0.
- Timeout: STAGE_READY[2] never rises -> 1024 cycles after STAGE_RESET_N[2] rises: SEQ_ERROR=1, ERR_STAGE=2, STAGE_RESET_N=0000, ALL_READY=0; the block stays in FAULT.
- Ready loss in RUN: drop STAGE_READY[1] and STAGE_READY[3] together -> next edge: ERR_STAGE=1, SEQ_ERROR=1, all stage resets asserted.
- Software reset: 1-cycle SW_RST_REQ pulse in RUN -> next edge: EXT_RST_REQ_N=0 for exactly 8 cycles, STAGE_RESET_N=0000, then HOLD; with no FABRIC_RESET_N activity, the full sequence repeats.
- Priority: SW_RST_REQ on the same cycle the timeout expires -> REQ entered, SEQ_ERROR stays 0; SW_RST_REQ from FAULT clears SEQ_ERROR and ERR_STAGE.
- Async reset mid-operation: FABRIC_RESET_N low in GAP and again during an EXT_RST_REQ_N pulse, between clock edges -> outputs return to reset values immediately; EXT_RST_REQ_N=1; after release, timing matches the nominal scenario.
